// File: rtl/fixed_latency_rv_collector.sv
// Ready/valid front end for a fixed-latency pipelined stage. A valid shift register
// tracks issues, and a credit-protected FIFO holds results until downstream takes them.
module fixed_latency_rv_collector #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              stage_issue,
  input  logic [DATA_W-1:0] stage_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  inflight,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LATENCY-1:0] r_vsr;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   r_occupancy;
  logic [CNT_W:0]     w_credit_used;
  logic               w_arrive;
  logic               w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every issued op owns a FIFO slot from issue until pop, so capture can never overrun.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_occupancy};
  assign in_ready      = ~rst & (w_credit_used < (CNT_W + 1)'(DEPTH));
  assign stage_issue   = in_valid & in_ready;
  assign w_arrive      = r_vsr[LATENCY-1];
  assign out_valid     = (r_occupancy != '0);
  assign out_data      = r_mem[r_rd_ptr];
  assign w_pop         = out_valid & out_ready;
  assign inflight      = r_inflight;
  assign occupancy     = r_occupancy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsr <= '0;
    end else begin
      r_vsr <= (r_vsr << 1) | LATENCY'(stage_issue);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_arrive) begin
      r_mem[r_wr_ptr] <= stage_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_inflight  <= '0;
      r_occupancy <= '0;
    end else begin
      if (w_arrive) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({stage_issue, w_arrive})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      unique case ({w_arrive, w_pop})
        2'b10:   r_occupancy <= r_occupancy + CNT_W'(1);
        2'b01:   r_occupancy <= r_occupancy - CNT_W'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    w_credit_used <= (CNT_W + 1)'(DEPTH));

  a_no_full_capture: assert property (@(posedge clk) disable iff (rst)
    !(w_arrive && (r_occupancy == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fixed_latency_rv_collector.sv
// Randomized bench for fixed_latency_rv_collector against a timestamp/queue model;
// two instances cover LATENCY=6/DEPTH=8 and LATENCY=3/DEPTH=5.
module tb_fixed_latency_rv_collector;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] stage_result = '0;

  logic          a_in_valid, a_out_ready, a_in_ready, a_issue, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [3:0]    a_inflight, a_occ;
  logic          b_in_valid, b_out_ready, b_in_ready, b_issue, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [2:0]    b_inflight, b_occ;

  logic          d_in_ready, d_issue, d_out_valid;
  logic [DW-1:0] d_out_data;
  logic [3:0]    d_inflight, d_occ;

  assign a_in_valid  = in_valid & ~sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign b_out_ready = out_ready & sel;
  assign d_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign d_issue     = sel ? b_issue     : a_issue;
  assign d_out_valid = sel ? b_out_valid : a_out_valid;
  assign d_out_data  = sel ? b_out_data  : a_out_data;
  assign d_inflight  = sel ? {1'b0, b_inflight} : a_inflight;
  assign d_occ       = sel ? {1'b0, b_occ}      : a_occ;

  always #5 clk = ~clk;

  fixed_latency_rv_collector #(.DATA_W(DW), .LATENCY(6), .DEPTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .stage_issue(a_issue), .stage_result(stage_result), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready), .inflight(a_inflight),
    .occupancy(a_occ)
  );

  fixed_latency_rv_collector #(.DATA_W(DW), .LATENCY(3), .DEPTH(5)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .stage_issue(b_issue), .stage_result(stage_result), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .inflight(b_inflight),
    .occupancy(b_occ)
  );

  // Model: pend_* = issued but not yet captured (issue cycle, value); fifo_v = buffered results.
  int unsigned   lat = 6;
  int unsigned   dep = 8;
  int unsigned   cyc = 0;
  int unsigned   pend_t[$];
  logic [DW-1:0] pend_v[$];
  logic [DW-1:0] fifo_v[$];
  int            n_issue = 0;
  int            n_pop = 0;
  int            val_mode = 0;
  int            first_valid_cyc = -1;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] gen_val();
    case (val_mode)
      1:       return DW'(n_issue);
      2:       return 32'hA5;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    logic exp_ready, exp_valid, arrive, issue, pop;
    arrive = (pend_t.size() != 0) && (pend_t[0] + lat == cyc);
    stage_result = arrive ? pend_v[0] : $urandom;
    #1;
    exp_ready = !rst && ((pend_t.size() + fifo_v.size()) < dep);
    exp_valid = (fifo_v.size() != 0);
    chk("in_ready", d_in_ready, exp_ready);
    chk("stage_issue", d_issue, in_valid & exp_ready);
    chk("out_valid", d_out_valid, exp_valid);
    if (exp_valid) chk("out_data", d_out_data, fifo_v[0]);
    chk("inflight", d_inflight, pend_t.size());
    chk("occupancy", d_occ, fifo_v.size());
    if (d_out_valid && first_valid_cyc < 0) first_valid_cyc = int'(cyc);
    issue = in_valid & exp_ready;
    pop   = exp_valid & out_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      pend_t.delete();
      pend_v.delete();
      fifo_v.delete();
    end else begin
      if (pop) begin
        void'(fifo_v.pop_front());
        n_pop++;
      end
      if (arrive) begin
        fifo_v.push_back(pend_v.pop_front());
        void'(pend_t.pop_front());
      end
      if (issue) begin
        pend_t.push_back(cyc);
        pend_v.push_back(gen_val());
        n_issue++;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((pend_t.size() + fifo_v.size()) != 0 && k < bound) begin
      tick();
      k++;
    end
    chk("drain_done", DW'(pend_t.size() + fifo_v.size()), '0);
  endtask

  task automatic do_reset(input logic s);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    sel = s;
    lat = s ? 3 : 6;
    dep = s ? 5 : 8;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, drops, k, stale;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset held with in_valid high
    in_valid = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("sc1_ready_after_reset", d_in_ready, 1'b1);

    // 2: single request, 0xA5
    val_mode = 2;
    c0 = int'(cyc);
    first_valid_cyc = -1;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (9) tick();
    chk("sc2_latency", DW'(first_valid_cyc - c0), 7);
    chk("sc2_occ_empty", d_occ, 0);

    // 3: 20 back-to-back, index echo
    val_mode = 1;
    n_issue = 0;
    n_pop = 0;
    drops = 0;
    k = 0;
    first_valid_cyc = -1;
    c0 = int'(cyc);
    out_ready = 1'b1;
    while (n_issue < 20 && k < 100) begin
      in_valid = 1'b1;
      if (d_in_ready !== 1'b1) drops++;
      tick();
      k++;
    end
    chk("sc3_ready_drops", DW'(drops), 0);
    chk("sc3_first_out", DW'(first_valid_cyc - c0), 7);
    drain(50);
    chk("sc3_pops", DW'(n_pop), 20);

    // 4: backpressure fill then release
    val_mode = 0;
    n_issue = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (16) tick();
    chk("sc4_issues", DW'(n_issue), 8);
    chk("sc4_occ_full", d_occ, 8);
    chk("sc4_ready_low", d_in_ready, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("sc4_ready_after_pop", d_in_ready, 1'b1);
    drain(50);

    // 5: DEPTH=5, LATENCY=3, random stalls, wraps several times
    do_reset(1'b1);
    n_issue = 0;
    n_pop = 0;
    k = 0;
    while (n_issue < 20 && k < 400) begin
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("sc5_issues", DW'(n_issue), 20);
    drain(100);
    chk("sc5_pops", DW'(n_pop), 20);

    // 6: mid-operation reset with inflight=4, occupancy=3
    do_reset(1'b0);
    n_issue = 0;
    k = 0;
    out_ready = 1'b0;
    while (!(pend_t.size() == 4 && fifo_v.size() == 3) && k < 40) begin
      in_valid = (n_issue < 7);
      tick();
      k++;
    end
    chk("sc6_inflight_pre", d_inflight, 4);
    chk("sc6_occ_pre", d_occ, 3);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("sc6_inflight_post", d_inflight, 0);
    chk("sc6_occ_post", d_occ, 0);
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      if (d_out_valid !== 1'b0) stale++;
      tick();
    end
    chk("sc6_stale_valid", DW'(stale), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_latency_rv_collector.md
Name: fixed_latency_rv_collector

Overview:
- Receive-side companion for fixed-latency, fully pipelined ray-tracing compute stages (e.g. ray-box or ray-triangle units).
- Accepts upstream ready/valid requests and issues each one to the stage.
- Tracks in-flight operations with a valid shift register and captures each result exactly LATENCY cycles after issue.
- Buffers results in a credit-protected FIFO and presents them downstream on a ready/valid interface, so stage output is never lost under backpressure.

Parameters:
- DATA_W, 32: result width.
- LATENCY, 6: stage latency in cycles, issue to result; must be >= 1.
- DEPTH, 8: result FIFO entries; must be >= 1. DEPTH >= LATENCY+2 is required for one-per-cycle throughput. Smaller values are legal but throttle issue.
- CNT_W, $clog2(DEPTH+1): width of the count outputs.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  collector can accept and issue a request.
- stage_issue  out  1  start pulse to stage; equals in_valid & in_ready.
- stage_result  in  DATA_W  stage output; meaningful only LATENCY cycles after an issue.
- out_valid  out  1  FIFO head valid.
- out_data  out  DATA_W  FIFO head data.
- out_ready  in  1  downstream accepts head.
- inflight  out  CNT_W  issued, not yet captured.
- occupancy  out  CNT_W  entries held in FIFO.

Behaviour:
- Reset: while rst=1 at a clock edge:
  - shift register cleared; rd_ptr, wr_ptr, inflight and occupancy set to 0.
  - in_ready is forced 0 combinationally while rst is high.
  - out_valid=0; out_data is don't-care.
- Mid-operation reset discards all in-flight and buffered items. Stage results arriving later are ignored because their shift-register bits are gone.
- Credit rule: in_ready = ~rst & ((inflight + occupancy) < DEPTH).
  - Computed only from registered state; there is no combinational path from out_ready or in_valid to in_ready.
  - Widen the sum to CNT_W+1 bits.
- Issue tracking:
  - vsr[LATENCY-1:0] shifts every cycle: vsr[0] <= stage_issue, vsr[i] <= vsr[i-1].
  - arrive = vsr[LATENCY-1]. Issue in cycle t gives arrive=1 in cycle t+LATENCY.
- Capture: when arrive=1, mem[wr_ptr] <= stage_result; wr_ptr advances, wrapping DEPTH-1 -> 0. DEPTH need not be a power of two.
- Pop: pop = out_valid & out_ready; rd_ptr advances with the same wrap rule.
- out_valid = (occupancy != 0); out_data = mem[rd_ptr].
- Counters:
  - inflight += stage_issue - arrive.
  - occupancy += arrive - pop.
  - Simultaneous increment and decrement leaves the count unchanged.
- Latency: issue in cycle t -> out_valid=1 with that data in cycle t+LATENCY+1, assuming an empty FIFO.
- Ordering: strict FIFO; results leave in issue order.
- Boundaries:
  - The credit rule guarantees no capture into a full FIFO and no inflight overflow.
  - Pop on an empty FIFO is impossible, since out_valid=0.
  - At occupancy=DEPTH with arrive=0 and pop=1, in_ready rises the following cycle.
  - Write and read of the same entry in one cycle (occupancy 0 with arrive) is legal: out_valid stays 0 that cycle and the new data appears next cycle.
- Simulation assertions (non-synthesizable):
  - inflight + occupancy <= DEPTH.
  - arrive with occupancy == DEPTH never occurs.

Test Plan:
All scenarios use LATENCY=6, DEPTH=8 unless stated.
1. Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0 and stage_issue=0 throughout; after release in_ready=1, out_valid=0, inflight=0, occupancy=0.
2. Single request: issue at cycle 0, drive stage_result=0xA5 at cycle 6 -> out_valid=1 and out_data=0xA5 at cycle 7; with out_ready=1, occupancy returns to 0 at cycle 8.
3. Streaming: 20 requests back to back, out_ready=1, stage echoes an issue index -> in_ready never drops; outputs 0..19 appear one per cycle starting 7 cycles after the first issue.
4. Backpressure: out_ready=0, in_valid=1 continuously -> exactly 8 issues, then in_ready=0; occupancy=8 at cycle 14; then assert out_ready=1 -> in_ready=1 the cycle after the first pop, and order is preserved.
5. Wrap and random stall: 3*DEPTH+5 items with random out_ready (50%), DEPTH=5, LATENCY=3 -> all items delivered in order, no loss or duplication, assertions never fire, pointers wrap correctly.
6. Mid-operation reset: reset with inflight=4, occupancy=3 -> all counts 0 next cycle; stale stage_result values driven over the following 6 cycles never raise out_valid.
